// File: rtl/wb_trace_buffer_pkg.sv
// wb_trace_buffer_pkg: shared definitions for the writeback trace buffer.
// State encodings and trace-entry field layout. The layout is
// {ts, pc, reg, data}, with data at bit 0.
// WB_TRACE_TIMESTAMP_EN adds a 16-bit timestamp field at the top of each entry.
package wb_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif

    // Total bits per stored entry.
    function automatic int entry_w(input int pc_w, input int reg_w, input int data_w);
        return pc_w + reg_w + data_w + TS_W;
    endfunction

    // Low bit of the register field.
    function automatic int reg_lsb(input int data_w);
        return data_w;
    endfunction

    // Low bit of the PC field.
    function automatic int pc_lsb(input int reg_w, input int data_w);
        return data_w + reg_w;
    endfunction

    // Low bit of the timestamp field. Only meaningful when TS_W != 0.
    function automatic int ts_lsb(input int pc_w, input int reg_w, input int data_w);
        return data_w + reg_w + pc_w;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x WIDTH entry storage.
// Has one synchronous write port and one asynchronous read port, so the
// head entry is visible show-ahead. The storage has no reset because
// validity is tracked by the level and pointer logic in the parent.
module trace_ram
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 49
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle at most.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: writeback trace capture for the 5-stage pipeline.
// Records register writes (excluding r0) from the MW stage into a circular
// buffer. Capture stops on a PC trigger plus a post-trigger window. Event
// counters saturate. Captured entries are drained on a valid/ready port.
// Optional: WB_TRACE_TIMESTAMP_EN adds a 16-bit cycle timestamp per entry
// and the rd_time output.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 12,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              arm,
    input  logic              mode_stop,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [ADDR_W:0]   post_count,
    input  logic              wb_valid,
    input  logic [PC_W-1:0]   wb_pc,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [PC_W-1:0]   rd_pc,
    output logic [REG_W-1:0]  rd_reg,
    output logic [DATA_W-1:0] rd_data,
`ifdef WB_TRACE_TIMESTAMP_EN
    output logic [15:0]       rd_time,
`endif
    output logic [1:0]        state,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  cnt_commit,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_flush
);

    localparam int EW  = entry_w(PC_W, REG_W, DATA_W);
    localparam int RL  = reg_lsb(DATA_W);
    localparam int PL  = pc_lsb(REG_W, DATA_W);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    state_t             st, st_nxt;
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_W:0]    lvl, remaining;
    logic               ovf;
    logic [EW-1:0]      ram_wdata, ram_rdata;

    logic active, rec, full, drop, store, hit, pop, clear;

    assign active = (st == ST_CAPTURE) || (st == ST_POST);
    assign rec    = active && wb_valid && (wb_reg != '0);
    assign full   = (lvl == FULL_LVL);
    assign drop   = rec && full && mode_stop;
    assign store  = rec && !drop;
    assign hit    = store && (wb_pc == trig_pc);
    assign pop    = (st == ST_DRAIN) && (lvl != '0) && rd_ready;
    // arm restarts from IDLE/CAPTURE/POST but is ignored while draining.
    assign clear  = arm && (st != ST_DRAIN);

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int TL = ts_lsb(PC_W, REG_W, DATA_W);
    logic [15:0] ts;
    assign ram_wdata = {ts, wb_pc, wb_reg, wb_data};
    assign rd_time   = ram_rdata[TL +: 16];
`else
    assign ram_wdata = {wb_pc, wb_reg, wb_data};
`endif

    trace_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(EW)) u_ram (
        .clock   (clock),
        .wr_en   (store && !clear),
        .wr_addr (wr_ptr),
        .wr_data (ram_wdata),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    assign rd_data  = ram_rdata[DATA_W-1:0];
    assign rd_reg   = ram_rdata[RL +: REG_W];
    assign rd_pc    = ram_rdata[PL +: PC_W];
    assign rd_valid = (st == ST_DRAIN) && (lvl != '0);
    assign state    = st;
    assign level    = lvl;
    assign overflow = ovf;

    // State register.
    always_ff @(posedge clock) begin
        if (ctrl_reset) st <= ST_IDLE;
        else            st <= st_nxt;
    end

    // Next-state logic. A full buffer in stop mode ends capture immediately.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:    if (arm) st_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (arm)       st_nxt = ST_CAPTURE;
                else if (drop) st_nxt = ST_DRAIN;
                else if (hit)  st_nxt = (post_count == '0) ? ST_DRAIN : ST_POST;
            end
            ST_POST: begin
                if (arm)                           st_nxt = ST_CAPTURE;
                else if (drop)                     st_nxt = ST_DRAIN;
                else if (store && remaining == 1)  st_nxt = ST_DRAIN;
            end
            ST_DRAIN:   if (lvl == '0) st_nxt = ST_IDLE;
            default:    st_nxt = ST_IDLE;
        endcase
    end

    // Pointers, level, overflow, post window and saturating counters.
    always_ff @(posedge clock) begin
        if (ctrl_reset || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lvl        <= '0;
            remaining  <= '0;
            ovf        <= 1'b0;
            cnt_commit <= '0;
            cnt_stall  <= '0;
            cnt_flush  <= '0;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts         <= '0;
`endif
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
                // When full, the oldest entry is overwritten, so the head moves too.
                if (full) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    ovf    <= 1'b1;
                end else begin
                    lvl <= lvl + 1'b1;
                end
            end
            if (drop) ovf <= 1'b1;
            if (st == ST_CAPTURE && hit) remaining <= post_count;
            if (st == ST_POST && store)  remaining <= remaining - 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                lvl    <= lvl - 1'b1;
            end
            if (active) begin
                if (wb_valid && !(&cnt_commit)) cnt_commit <= cnt_commit + 1'b1;
                if (stall && !(&cnt_stall))     cnt_stall  <= cnt_stall + 1'b1;
                if (flush && !(&cnt_flush))     cnt_flush  <= cnt_flush + 1'b1;
`ifdef WB_TRACE_TIMESTAMP_EN
                ts <= ts + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed bench for wb_trace_buffer at DEPTH=4.
// Covers wrap, stop-when-full, the post window, filtering and counters,
// drain backpressure, and reset.
module tb_wb_trace_buffer;

    localparam int DEPTH = 4, ADDR_W = 2, DATA_W = 32, REG_W = 5, PC_W = 12, CNT_W = 32;

    logic              clock = 1'b0;
    logic              ctrl_reset, arm, mode_stop, wb_valid, stall, flush, rd_ready;
    logic [PC_W-1:0]   trig_pc, wb_pc, rd_pc;
    logic [ADDR_W:0]   post_count, level;
    logic [REG_W-1:0]  wb_reg, rd_reg;
    logic [DATA_W-1:0] wb_data, rd_data;
    logic              rd_valid, overflow;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt_commit, cnt_stall, cnt_flush;
`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0]       rd_time;
`endif

    int n_chk = 0, n_pass = 0;

    always #5 clock = ~clock;

    wb_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W),
                      .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .arm(arm), .mode_stop(mode_stop),
        .trig_pc(trig_pc), .post_count(post_count), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_reg(wb_reg), .wb_data(wb_data), .stall(stall), .flush(flush),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_reg(rd_reg),
        .rd_data(rd_data),
`ifdef WB_TRACE_TIMESTAMP_EN
        .rd_time(rd_time),
`endif
        .state(state), .level(level), .overflow(overflow),
        .cnt_commit(cnt_commit), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] dat(input int pc, input int r);
        return 32'hD000_0000 + 32'(pc * 256 + r);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wr(input int pc, input int r);
        wb_valid = 1'b1;
        wb_pc    = PC_W'(pc);
        wb_reg   = REG_W'(r);
        wb_data  = dat(pc, r);
        step();
        wb_valid = 1'b0;
    endtask

    // Pops n entries with ready held high, checking pc/reg/data in order.
    task automatic drain(input string tag, input int pc0, input int r0, input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vld"},  64'(rd_valid), 64'd1);
            chk({tag, "_reg"},  64'(rd_reg),   64'(r0 + i));
            chk({tag, "_pc"},   64'(rd_pc),    64'(pc0 + i));
            chk({tag, "_data"}, 64'(rd_data),  64'(dat(pc0 + i, r0 + i)));
            step();
        end
        rd_ready = 1'b0;
        chk({tag, "_empty"}, 64'(level), 64'd0);
        chk({tag, "_vld0"},  64'(rd_valid), 64'd0);
        step();
        chk({tag, "_idle"},  64'(state), 64'd0);
    endtask

    initial begin
        ctrl_reset = 1'b1; arm = 1'b0; mode_stop = 1'b0; wb_valid = 1'b0; stall = 1'b0;
        flush = 1'b0; rd_ready = 1'b0; trig_pc = '0; post_count = '0;
        wb_pc = '0; wb_reg = '0; wb_data = '0;
        step(); step();
        ctrl_reset = 1'b0;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_vld",   64'(rd_valid), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_cnt",   64'(cnt_commit | cnt_stall | cnt_flush), 64'd0);

        // 1: wrap and drain
        mode_stop = 1'b0; trig_pc = 12'd5; post_count = 3'd0;
        pulse_arm();
        chk("t1_cap", 64'(state), 64'd1);
        for (int i = 0; i < 6; i++) wr(i, i + 1);
        chk("t1_state",  64'(state), 64'd3);
        chk("t1_level",  64'(level), 64'd4);
        chk("t1_ovf",    64'(overflow), 64'd1);
        chk("t1_commit", 64'(cnt_commit), 64'd6);
        drain("t1", 2, 3, 4);

        // 2: stop when full
        mode_stop = 1'b1; trig_pc = 12'hFFF;
        pulse_arm();
        chk("t2_clr_ovf", 64'(overflow), 64'd0);
        chk("t2_clr_lvl", 64'(level), 64'd0);
        chk("t2_clr_cnt", 64'(cnt_commit), 64'd0);
        for (int i = 0; i < 4; i++) wr(16 + i, i + 1);
        chk("t2_full_cap", 64'(state), 64'd1);
        chk("t2_full_ovf", 64'(overflow), 64'd0);
        wr(20, 5);
        chk("t2_state", 64'(state), 64'd3);
        chk("t2_level", 64'(level), 64'd4);
        chk("t2_ovf",   64'(overflow), 64'd1);
        drain("t2", 16, 1, 4);

        // 3: post-trigger window
        mode_stop = 1'b0; trig_pc = 12'd2; post_count = 3'd2;
        pulse_arm();
        wr(2, 1);
        chk("t3_post", 64'(state), 64'd2);
        wr(3, 2);
        chk("t3_post2", 64'(state), 64'd2);
        wr(4, 3);
        chk("t3_drain", 64'(state), 64'd3);
        wr(5, 4);
        chk("t3_level",  64'(level), 64'd3);
        chk("t3_commit", 64'(cnt_commit), 64'd3);
        drain("t3", 2, 1, 3);

        // 4: r0 filtering and counters (last stall cycle also flushes)
        trig_pc = 12'hFFF; post_count = 3'd0;
        pulse_arm();
        wr(32, 0); wr(33, 1); wr(34, 0);
        stall = 1'b1; step(); step();
        flush = 1'b1; step();
        stall = 1'b0; flush = 1'b0;
        chk("t4_level",  64'(level), 64'd1);
        chk("t4_commit", 64'(cnt_commit), 64'd3);
        chk("t4_stall",  64'(cnt_stall), 64'd3);
        chk("t4_flush",  64'(cnt_flush), 64'd1);
        chk("t4_state",  64'(state), 64'd1);

        // 5: drain backpressure, arm ignored while draining
        trig_pc = 12'd48;
        wr(48, 7);
        chk("t5_state", 64'(state), 64'd3);
        chk("t5_level", 64'(level), 64'd2);
        pulse_arm();
        chk("t5_arm_state", 64'(state), 64'd3);
        chk("t5_arm_level", 64'(level), 64'd2);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_vld", 64'(rd_valid), 64'd1);
            chk("t5_hold_reg", 64'(rd_reg), 64'd1);
            chk("t5_hold_pc",  64'(rd_pc), 64'd33);
            step();
        end
        chk("t5_hold_level", 64'(level), 64'd2);
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("t5_pop_level", 64'(level), 64'd1);
        chk("t5_next_reg",  64'(rd_reg), 64'd7);
        chk("t5_next_data", 64'(rd_data), 64'(dat(48, 7)));
        drain("t5", 48, 7, 1);

        // 6: reset mid-POST
        trig_pc = 12'd64; post_count = 3'd4;
        pulse_arm();
        wr(64, 1); wr(65, 2);
        stall = 1'b1; wr(66, 3); stall = 1'b0;
        chk("t6_post",  64'(state), 64'd2);
        chk("t6_level", 64'(level), 64'd3);
        chk("t6_stall", 64'(cnt_stall), 64'd1);
        ctrl_reset = 1'b1; step(); ctrl_reset = 1'b0;
        chk("t6_state", 64'(state), 64'd0);
        chk("t6_lvl0",  64'(level), 64'd0);
        chk("t6_vld",   64'(rd_valid), 64'd0);
        chk("t6_ovf",   64'(overflow), 64'd0);
        chk("t6_cnt",   64'(cnt_commit | cnt_stall | cnt_flush), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Synthesizable writeback trace buffer for the 5-stage pipeline. It taps the MW-stage writeback (valid, pc, destination register, data) and captures register-write events into a circular buffer with a PC-match trigger and post-trigger window. It keeps saturating commit, stall and flush counters, and drains captured entries over a valid/ready port. This replaces hand-scanning of $display dumps in skeleton simulations and works in hardware as well.

Parameters:
DEPTH, 16, number of trace entries (power of 2)
ADDR_W, 4, log2(DEPTH)
DATA_W, 32, writeback data width
REG_W, 5, register index width
PC_W, 12, captured PC width (matches imem address)
CNT_W, 32, event counter width

Ports:
clock  in  1  system clock; all state updates on posedge
ctrl_reset  in  1  synchronous, active-high reset
arm  in  1  pulse: clear buffer/counters, enter CAPTURE
mode_stop  in  1  0 = wrap (overwrite oldest), 1 = stop when full
trig_pc  in  PC_W  trigger PC
post_count  in  ADDR_W+1  entries to record after the trigger entry
wb_valid  in  1  RegWrite_from_mw
wb_pc  in  PC_W  PC of the writeback instruction
wb_reg  in  REG_W  regDst_from_mw
wb_data  in  DATA_W  writeback data
stall  in  1  pipeline stall indicator
flush  in  1  branch/jump flush indicator
rd_ready  in  1  consumer accepts head entry
rd_valid  out  1  head entry available
rd_pc  out  PC_W  head entry PC
rd_reg  out  REG_W  head entry register
rd_data  out  DATA_W  head entry data
state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DRAIN
level  out  ADDR_W+1  entries held (0..DEPTH)
overflow  out  1  sticky: an entry was dropped or overwritten
cnt_commit  out  CNT_W  wb_valid events while capturing
cnt_stall  out  CNT_W  stall cycles while capturing
cnt_flush  out  CNT_W  flush cycles while capturing

Behaviour:
- Reset is synchronous and active-high on ctrl_reset: state IDLE; pointers, level, overflow and all counters go to 0; rd_valid is 0.
- Record condition: state is CAPTURE or POST, wb_valid=1 and wb_reg!=0. Writes to r0 are never recorded but do count in cnt_commit.
- Recording writes the entry at wr_ptr on the clock edge; wr_ptr increments mod DEPTH; level increments. level and the entry are visible on the next cycle.
- Full (level==DEPTH) on a record:
  - mode_stop=0: overwrite the oldest entry; rd_ptr increments; level stays at DEPTH; overflow is set.
  - mode_stop=1: drop the entry, set overflow, go to DRAIN.
- IDLE: ignores wb_*. On arm, go to CAPTURE with pointers, level, overflow and counters cleared.
- CAPTURE: a recorded entry with wb_pc==trig_pc is stored, then:
  - post_count==0: go to DRAIN.
  - otherwise: go to POST with remaining=post_count.
- POST: each recorded entry decrements remaining; when it reaches 0, go to DRAIN on the same edge. A trig_pc match in POST has no effect.
- arm in CAPTURE or POST restarts the capture (same clearing as from IDLE). arm in DRAIN is ignored.
- DRAIN: rd_valid = (level!=0). rd_pc, rd_reg and rd_data are the entry at rd_ptr, show-ahead and combinational from storage. When rd_valid and rd_ready are both 1: rd_ptr increments, level decrements. When level==0, go to IDLE on the next edge.
- Counters update only in CAPTURE and POST and saturate at all-ones. stall and flush in the same cycle increment both counters.
- Reset mid-capture or mid-drain discards all contents.

Optional Feature:
- WB_TRACE_TIMESTAMP_EN defined:
  - a free-running 16-bit cycle counter runs in CAPTURE/POST and is cleared on arm;
  - each entry also stores that counter's value;
  - an extra output port rd_time [15:0] presents it with the head entry.
- Not defined: no timestamp storage and no rd_time port.

Decomposition:
- Shared header wb_trace_defs: state encodings (ST_IDLE..ST_DRAIN) and entry field offsets/width (PC_W+REG_W+DATA_W, plus 16 when timestamps are enabled).
- One sub-module, trace_ram: DEPTH x entry-width storage, one synchronous write port, one asynchronous read port.
- FSM, pointers and counters live in wb_trace_buffer.

Test Plan:
1. Wrap and drain: DEPTH=4, mode_stop=0, post_count=0. Arm, then write r1..r6 at pc 0..5, with pc 5 = trig_pc. Expect DRAIN, level=4, overflow=1. With rd_ready=1, expect r3,r4,r5,r6 in order, then IDLE.
2. Stop when full: mode_stop=1, 5 writes, no trigger. Expect DRAIN after the 5th with overflow=1 and entries 1..4 intact.
3. Post-trigger window: trig at pc 2, post_count=2. Expect exactly 2 more entries recorded (total 3 with write regs 1..3), then DRAIN. A write in the next cycle is not recorded.
4. Filtering and counters: wb_reg=0 writes plus 3 stall cycles and 1 flush cycle. Expect r0 not recorded, cnt_commit counting the r0 events, cnt_stall=3, cnt_flush=1.
5. Drain backpressure: hold rd_ready=0 for 5 cycles with level=2. Expect rd_valid=1 and the same head entry throughout. Then 1 cycle of ready: level becomes 1 and the next entry appears.
6. Reset: assert ctrl_reset in POST with level=3. Next cycle expect state=0, level=0, rd_valid=0, all counters 0.
